// File: rtl/risc_ctrl_skid_reg_if.sv
// risc_ctrl_skid_reg_if
//   Handshake bundle between the RISC control decoder, the control skid
//   register and the execute stage.
//   Signals:
//     in_valid/in_ready   decoder -> stage handshake
//     in_ctrl/in_op       control word and decode field from the decoder
//     flush               discard everything held in the stage
//     out_valid/out_ready stage -> execute handshake
//     out_ctrl/out_op     control word and decode field to execute
//   Modports:
//     slave   the skid register itself
//     master  the environment (decoder + execute stage) driving it
interface risc_ctrl_skid_reg_if #(
    parameter int unsigned CTRL_W = 31,
    parameter int unsigned OP_W   = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [OP_W-1:0]   in_op;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [OP_W-1:0]   out_op;

    modport slave (
        input  in_valid, in_ctrl, in_op, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_op
    );

    modport master (
        output in_valid, in_ctrl, in_op, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_op
    );
endinterface

// File: rtl/risc_ctrl_skid_reg.sv
// risc_ctrl_skid_reg
//   Two-entry skid register behind the combinational RISC control decoder.
//   Main register M drives the execute stage; skid register S absorbs one
//   word when the execute stage stalls, so in_ready can be a plain flop.
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous reset, active-high
//     bus         risc_ctrl_skid_reg_if.slave (valid/ready in and out, flush)
//     stall_cnt   back-pressure cycle counter (RISC_CTRL_PERF_EN only)
//   Build option:
//     RISC_CTRL_PERF_EN  adds CNT_W and the saturating stall_cnt output.
module risc_ctrl_skid_reg #(
    parameter int unsigned CTRL_W = 31,
    parameter int unsigned OP_W   = 8
`ifdef RISC_CTRL_PERF_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    risc_ctrl_skid_reg_if.slave        bus
`ifdef RISC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
    logic [OP_W-1:0]   m_op_q, s_op_q;

    logic acc, drn;
    logic m_load, m_from_s, s_load;

    assign acc = bus.in_valid & in_ready_q;
    assign drn = out_valid_q & bus.out_ready;

    always_comb begin
        state_d  = state_q;
        m_load   = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        if (bus.flush) begin
            // Any offered word is dropped; a concurrent drain has already
            // completed on the execute side, so only the state is cleared.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        m_load  = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && drn) begin
                        m_load = 1'b1;
                    end else if (acc) begin
                        s_load  = 1'b1;
                        state_d = ST_FULL;
                    end else if (drn) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drn) begin
                        m_load   = 1'b1;
                        m_from_s = 1'b1;
                        state_d  = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered alongside the state so neither ready
    // nor valid has a combinational path from the opposite side.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Data registers carry no reset: validity lives in the state, and the
    // outputs are masked while invalid. They load only on accept/shift.
    always_ff @(posedge clk) begin
        if (m_load) begin
            m_ctrl_q <= m_from_s ? s_ctrl_q : bus.in_ctrl;
            m_op_q   <= m_from_s ? s_op_q   : bus.in_op;
        end
        if (s_load) begin
            s_ctrl_q <= bus.in_ctrl;
            s_op_q   <= bus.in_op;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = out_valid_q ? m_ctrl_q : '0;
    assign bus.out_op    = out_valid_q ? m_op_q   : '0;

`ifdef RISC_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !bus.out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_risc_ctrl_skid_reg.sv
// tb_risc_ctrl_skid_reg
//   Directed self-checking bench for risc_ctrl_skid_reg. Inputs change 1
//   time unit after the rising edge; outputs are checked at the same point.
//   With RISC_CTRL_PERF_EN defined a second instance with CNT_W=3 shares the
//   stimulus to observe counter saturation.
module tb_risc_ctrl_skid_reg;

    localparam int unsigned CTRL_W = 31;
    localparam int unsigned OP_W   = 8;

    localparam logic [CTRL_W-1:0] W_A = 31'h0AAA_5501;
    localparam logic [CTRL_W-1:0] W_B = 31'h1234_5678;
    localparam logic [CTRL_W-1:0] W_C = 31'h7FFF_0003;
    localparam logic [CTRL_W-1:0] W_D = 31'h5A5A_5A5A;
    localparam logic [OP_W-1:0]   O_A = 8'hA1;
    localparam logic [OP_W-1:0]   O_B = 8'hB2;
    localparam logic [OP_W-1:0]   O_C = 8'hC3;
    localparam logic [OP_W-1:0]   O_D = 8'hD4;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    risc_ctrl_skid_reg_if #(.CTRL_W(CTRL_W), .OP_W(OP_W)) bus ();

`ifdef RISC_CTRL_PERF_EN
    logic [15:0] stall_cnt;
    logic [2:0]  stall_cnt3;

    risc_ctrl_skid_reg_if #(.CTRL_W(CTRL_W), .OP_W(OP_W)) bus3 ();
    assign bus3.in_valid  = bus.in_valid;
    assign bus3.in_ctrl   = bus.in_ctrl;
    assign bus3.in_op     = bus.in_op;
    assign bus3.flush     = bus.flush;
    assign bus3.out_ready = bus.out_ready;

    risc_ctrl_skid_reg #(.CTRL_W(CTRL_W), .OP_W(OP_W), .CNT_W(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus3),
        .stall_cnt (stall_cnt3)
    );
`endif

    risc_ctrl_skid_reg #(.CTRL_W(CTRL_W), .OP_W(OP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef RISC_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [CTRL_W-1:0] c, input logic [OP_W-1:0] o);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_op    = o;
    endtask

    initial begin
        logic [CTRL_W-1:0] w;

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        offer(1'b0, '0, '0);

        // T1 reset
        repeat (3) step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_ctrl",  64'(bus.out_ctrl),  64'd0);
        chk("rst_out_op",    64'(bus.out_op),    64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        rst = 1'b0;
        chk("rel_in_ready0", 64'(bus.in_ready),  64'd0);
        step();
        chk("rel_in_ready1", 64'(bus.in_ready),  64'd1);

        // T2 streaming, one word per clock
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = 31'h1 << k;
            offer(1'b1, w, 8'(k));
            chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
            step();
            chk("stream_valid", 64'(bus.out_valid), 64'd1);
            chk("stream_ctrl",  64'(bus.out_ctrl),  64'(w));
            chk("stream_op",    64'(bus.out_op),    64'(k));
        end
        offer(1'b0, '0, '0);
        step();
        chk("stream_end_valid", 64'(bus.out_valid), 64'd0);
        chk("stream_end_ctrl",  64'(bus.out_ctrl),  64'd0);

        // T3 back-pressure
        bus.out_ready = 1'b0;
        offer(1'b1, W_A, O_A);
        step();
        chk("bp_a_ctrl",  64'(bus.out_ctrl), 64'(W_A));
        chk("bp_a_ready", 64'(bus.in_ready), 64'd1);
        offer(1'b1, W_B, O_B);
        step();
        chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_full_ctrl",  64'(bus.out_ctrl), 64'(W_A));
        offer(1'b1, W_C, O_C);
        repeat (2) step();
        chk("bp_hold_ctrl",  64'(bus.out_ctrl), 64'(W_A));
        chk("bp_hold_op",    64'(bus.out_op),   64'(O_A));
        chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_b_ctrl",  64'(bus.out_ctrl), 64'(W_B));
        chk("bp_b_op",    64'(bus.out_op),   64'(O_B));
        chk("bp_b_ready", 64'(bus.in_ready), 64'd1);
        step();
        offer(1'b0, '0, '0);
        chk("bp_c_ctrl", 64'(bus.out_ctrl), 64'(W_C));
        chk("bp_c_op",   64'(bus.out_op),   64'(O_C));
        step();
        chk("bp_done_valid", 64'(bus.out_valid), 64'd0);

        // T4 flush while FULL, with a new word offered
        bus.out_ready = 1'b0;
        offer(1'b1, W_A, O_A);
        step();
        offer(1'b1, W_B, O_B);
        step();
        chk("fl_full_ready", 64'(bus.in_ready), 64'd0);
        offer(1'b1, W_D, O_D);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        offer(1'b0, '0, '0);
        chk("fl_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_ctrl",  64'(bus.out_ctrl),  64'd0);
        chk("fl_op",    64'(bus.out_op),    64'd0);
        chk("fl_ready", 64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("fl_no_d_valid", 64'(bus.out_valid), 64'd0);

        // T5 flush together with a drain
        offer(1'b1, W_A, O_A);
        step();
        offer(1'b0, '0, '0);
        bus.flush = 1'b1;
        chk("fd_drain_valid", 64'(bus.out_valid), 64'd1);
        chk("fd_drain_ctrl",  64'(bus.out_ctrl),  64'(W_A));
        step();
        bus.flush = 1'b0;
        chk("fd_empty_valid", 64'(bus.out_valid), 64'd0);
        chk("fd_empty_ready", 64'(bus.in_ready),  64'd1);

        // reset mid-transfer with flush also high
        bus.out_ready = 1'b0;
        offer(1'b1, W_A, O_A);
        step();
        offer(1'b1, W_B, O_B);
        step();
        offer(1'b1, W_D, O_D);
        rst       = 1'b1;
        bus.flush = 1'b1;
        step();
        chk("rf_valid", 64'(bus.out_valid), 64'd0);
        chk("rf_ready", 64'(bus.in_ready),  64'd0);
        rst       = 1'b0;
        bus.flush = 1'b0;
        offer(1'b0, '0, '0);
        step();
        chk("rf_rel_ready", 64'(bus.in_ready),  64'd1);
        chk("rf_rel_valid", 64'(bus.out_valid), 64'd0);

`ifdef RISC_CTRL_PERF_EN
        // T6 stall counter
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus.out_ready = 1'b0;
        offer(1'b1, W_A, O_A);
        step();
        offer(1'b0, '0, '0);
        chk("perf_start", 64'(stall_cnt), 64'd0);
        repeat (5) step();
        chk("perf_5",   64'(stall_cnt),  64'd5);
        chk("perf3_5",  64'(stall_cnt3), 64'd5);
        repeat (5) step();
        chk("perf_10",  64'(stall_cnt),  64'd10);
        chk("perf3_sat", 64'(stall_cnt3), 64'd7);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        chk("perf_flush_keep", 64'(stall_cnt), 64'd11);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
